// File: rtl/mux_scan_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_reg
//   Registered CHANNELS-to-1 word selector with a one-cycle valid strobe.
//   It has two modes:
//     manual (mode=0): captures channel[sel] on load_en.
//     scan   (mode=1): an internal round-robin sweep captures one channel
//                      every SCAN_DIV clock cycles.
//
// Optional feature:
//   MUX_SCAN_PARITY_EN
//     When this macro is defined, the module adds the par_out port. par_out
//     holds the even-parity bit (XOR-reduction) of each captured word.
//
// Ports:
//   clk      in   1                 system clock, rising edge
//   rst      in   1                 asynchronous, active-high reset
//   mode     in   1                 0 = manual, 1 = scan
//   sel      in   $clog2(CHANNELS)  manual channel select
//   load_en  in   1                 manual capture strobe
//   data_in  in   CHANNELS*WIDTH    channel k = data_in[k*WIDTH +: WIDTH]
//   data_out out  WIDTH             registered selected word
//   ch_out   out  $clog2(CHANNELS)  channel index of data_out
//   valid    out  1                 one-cycle pulse per capture
//   sel_err  out  1                 last manual capture had sel >= CHANNELS
//   par_out  out  1                 parity of captured word (macro only)
// -----------------------------------------------------------------------------
module mux_scan_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SCAN_DIV = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [$clog2(CHANNELS)-1:0]   sel,
    input  logic                          load_en,
    input  logic [CHANNELS*WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [$clog2(CHANNELS)-1:0]   ch_out,
    output logic                          valid,
    output logic                          sel_err
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                          par_out
`endif
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    // Every sel code gets a slot, so an out-of-range sel can never index
    // past the end of the array. Slots beyond CHANNELS read as zero.
    localparam int NSLOT = 1 << SEL_W;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    // Even-parity bit of one data word.
    function automatic logic even_par(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    logic [WIDTH-1:0] chan_s [NSLOT];
    logic             sel_ok_s;

    state_t           state_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] idx_q;
    logic [WIDTH-1:0] data_out_q;
    logic [SEL_W-1:0] ch_out_q;
    logic             valid_q;
    logic             sel_err_q;
    logic             par_q;

    // Unpack the channel bus. The padding slots are tied to zero.
    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < CHANNELS) begin : g_real
            assign chan_s[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan_s[k] = '0;
        end
    end

    // The select is zero-extended before the range compare, so the compare
    // is well-formed even when CHANNELS is a power of two.
    assign sel_ok_s = ({{(32-SEL_W){1'b0}}, sel} < 32'(CHANNELS));

    // Mode tracking, scan sequencing and output capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_MANUAL;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            ch_out_q   <= '0;
            valid_q    <= 1'b0;
            sel_err_q  <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode != mode_q) begin
                // A mode-change edge only re-arms the FSM. It never captures.
                state_q <= mode ? S_SCAN : S_MANUAL;
                cnt_q   <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_MANUAL: begin
                        if (load_en) begin
                            ch_out_q <= sel;
                            valid_q  <= 1'b1;
                            if (sel_ok_s) begin
                                data_out_q <= chan_s[sel];
                                sel_err_q  <= 1'b0;
                                par_q      <= even_par(chan_s[sel]);
                            end else begin
                                data_out_q <= '0;
                                sel_err_q  <= 1'b1;
                                par_q      <= 1'b0;
                            end
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                    S_SCAN: begin
                        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                            cnt_q      <= '0;
                            data_out_q <= chan_s[idx_q];
                            ch_out_q   <= idx_q;
                            valid_q    <= 1'b1;
                            sel_err_q  <= 1'b0;
                            par_q      <= even_par(chan_s[idx_q]);
                            if (idx_q == SEL_W'(CHANNELS - 1)) begin
                                idx_q <= '0;
                            end else begin
                                idx_q <= idx_q + SEL_W'(1);
                            end
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_MANUAL;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out = data_out_q;
    assign ch_out   = ch_out_q;
    assign valid    = valid_q;
    assign sel_err  = sel_err_q;
`ifdef MUX_SCAN_PARITY_EN
    assign par_out  = par_q;
`else
    // Without the parity port, the parity register has no load. Synthesis
    // trims it.
    logic unused_par_s;
    assign unused_par_s = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_reg
//   Directed bench for mux_scan_reg.
//   DUT A: WIDTH=4, CHANNELS=4, SCAN_DIV=4, data 16'hDCBA.
//   DUT B: WIDTH=4, CHANNELS=3, data 12'hCBA. DUT B exercises the
//          invalid-select path.
// -----------------------------------------------------------------------------
module tb_mux_scan_reg;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode_a, load_a;
    logic [1:0]  sel_a;
    logic [15:0] data_in_a;
    logic [3:0]  data_out_a;
    logic [1:0]  ch_out_a;
    logic        valid_a, sel_err_a;

    logic        mode_b, load_b;
    logic [1:0]  sel_b;
    logic [11:0] data_in_b;
    logic [3:0]  data_out_b;
    logic [1:0]  ch_out_b;
    logic        valid_b, sel_err_b;

`ifdef MUX_SCAN_PARITY_EN
    logic        par_a, par_b;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(4)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode_a),
        .sel      (sel_a),
        .load_en  (load_a),
        .data_in  (data_in_a),
        .data_out (data_out_a),
        .ch_out   (ch_out_a),
        .valid    (valid_a),
        .sel_err  (sel_err_a)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .par_out  (par_a)
`endif
    );

    mux_scan_reg #(.WIDTH(4), .CHANNELS(3), .SCAN_DIV(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode_b),
        .sel      (sel_b),
        .load_en  (load_b),
        .data_in  (data_in_b),
        .data_out (data_out_b),
        .ch_out   (ch_out_b),
        .valid    (valid_b),
        .sel_err  (sel_err_b)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .par_out  (par_b)
`endif
    );

    // Single comparison point: count the check and report any mismatch.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_d [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic       exp_p [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // 1. Reset with arbitrary inputs, checked before any clock edge.
        rst = 1'b1;
        mode_a = 1'b1; sel_a = 2'd1; load_a = 1'b1; data_in_a = 16'h5A3C;
        mode_b = 1'b1; sel_b = 2'd3; load_b = 1'b1; data_in_b = 12'h777;
        #3;
        check("rst_data",  data_out_a, 4'h0);
        check("rst_ch",    ch_out_a,   2'd0);
        check("rst_valid", valid_a,    1'b0);
        check("rst_err",   sel_err_a,  1'b0);
        check("rst_b_val", valid_b,    1'b0);
`ifdef MUX_SCAN_PARITY_EN
        check("rst_par",   par_a,      1'b0);
`endif
        mode_a = 1'b0; load_a = 1'b0; data_in_a = 16'hDCBA;
        mode_b = 1'b0; load_b = 1'b0; data_in_b = 12'hCBA;
        tick();
        rst = 1'b0;

        // 2. Manual capture of channel 2, then hold against a data_in change.
        sel_a = 2'd2; load_a = 1'b1;
        tick();
        check("man_data",  data_out_a, 4'hC);
        check("man_ch",    ch_out_a,   2'd2);
        check("man_valid", valid_a,    1'b1);
        check("man_err",   sel_err_a,  1'b0);
`ifdef MUX_SCAN_PARITY_EN
        check("man_par",   par_a,      1'b0);
`endif
        load_a = 1'b0; data_in_a = 16'h0000;
        tick();
        check("man_pulse", valid_a,    1'b0);
        check("man_hold",  data_out_a, 4'hC);
        tick();
        check("man_hold2", data_out_a, 4'hC);

        // 5. Invalid select on the 3-channel instance.
        sel_b = 2'd3; load_b = 1'b1;
        tick();
        check("inv_data",  data_out_b, 4'h0);
        check("inv_ch",    ch_out_b,   2'd3);
        check("inv_valid", valid_b,    1'b1);
        check("inv_err",   sel_err_b,  1'b1);
`ifdef MUX_SCAN_PARITY_EN
        check("inv_par",   par_b,      1'b0);
`endif
        load_b = 1'b0;
        tick();
        check("inv_pulse", valid_b,    1'b0);
        check("inv_hold",  sel_err_b,  1'b1);
        sel_b = 2'd1; load_b = 1'b1;
        tick();
        check("ok_data",   data_out_b, 4'hB);
        check("ok_ch",     ch_out_b,   2'd1);
        check("ok_err",    sel_err_b,  1'b0);
`ifdef MUX_SCAN_PARITY_EN
        check("ok_par",    par_b,      1'b1);
`endif
        load_b = 1'b0;

        // 3. Scan sweep: switch edge, then one emission every 4 edges.
        data_in_a = 16'hDCBA; mode_a = 1'b1;
        tick();
        check("sw_valid",  valid_a,    1'b0);
        for (int e = 0; e < 5; e++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                check("scan_valid", valid_a, (c == 4));
                if (c == 4) begin
                    check("scan_data", data_out_a, exp_d[e]);
                    check("scan_ch",   ch_out_a,   e % 4);
`ifdef MUX_SCAN_PARITY_EN
                    check("scan_par",  par_a,      exp_p[e]);
`endif
                end
            end
        end

        // 4. Leave scan two cycles after the ch1 emission, with load_en set.
        for (int c = 1; c <= 4; c++) tick();
        check("ch1_data",  data_out_a, 4'hB);
        check("ch1_valid", valid_a,    1'b1);
        tick();
        mode_a = 1'b0; load_a = 1'b1; sel_a = 2'd3;
        tick();
        check("msw_valid", valid_a,    1'b0);
        check("msw_data",  data_out_a, 4'hB);
        check("msw_ch",    ch_out_a,   2'd1);
        load_a = 1'b0; mode_a = 1'b1;
        tick();
        check("rsw_valid", valid_a,    1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("rescan_valid", valid_a, (c == 4));
        end
        check("rescan_data", data_out_a, 4'hA);
        check("rescan_ch",   ch_out_a,   2'd0);

        // Back-to-back manual captures keep valid high.
        mode_a = 1'b0;
        tick();
        check("b2b_sw", valid_a, 1'b0);
        load_a = 1'b1; sel_a = 2'd0;
        tick();
        check("b2b0_data",  data_out_a, 4'hA);
        check("b2b0_valid", valid_a,    1'b1);
        sel_a = 2'd3;
        tick();
        check("b2b1_data",  data_out_a, 4'hD);
        check("b2b1_ch",    ch_out_a,   2'd3);
        check("b2b1_valid", valid_a,    1'b1);
        load_a = 1'b0;
        tick();
        check("b2b_end",    valid_a,    1'b0);
        check("b2b_hold",   data_out_a, 4'hD);

        // 6. Async reset mid-scan after a ch1 capture.
        mode_a = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) tick();
        check("pre_data",  data_out_a, 4'hB);
`ifdef MUX_SCAN_PARITY_EN
        check("pre_par",   par_a,      1'b1);
`endif
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_data",  data_out_a, 4'h0);
        check("arst_ch",    ch_out_a,   2'd0);
        check("arst_valid", valid_a,    1'b0);
        check("arst_err",   sel_err_a,  1'b0);
`ifdef MUX_SCAN_PARITY_EN
        check("arst_par",   par_a,      1'b0);
`endif
        #1;
        rst = 1'b0;
        tick();
        check("post_sw", valid_a, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("post_valid", valid_a, (c == 4));
        end
        check("post_data", data_out_a, 4'hA);
        check("post_ch",   ch_out_a,   2'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("post_par",  par_a,      1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
